// File: rtl/mips_pkg.sv
// Shared encodings for the 5-stage MIPS hazard unit: opcodes, Tuse/Tnew
// codes, forward-select enums and small comparator helpers.
package mips_pkg;

   typedef logic [4:0] reg_t;
   typedef logic [1:0] tuse_t;
   typedef logic [1:0] tnew_t;

   // Tuse of 3 means the operand is never read, so it can never stall
   localparam tuse_t TUSE_NONE = 2'd3;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] F_JR     = 6'h08;
   localparam logic [5:0] F_ADDU   = 6'h21;
   localparam logic [5:0] F_SUBU   = 6'h23;
   localparam logic [5:0] F_SLT    = 6'h2a;

   // ID-stage operand source
   typedef enum logic [1:0] {FWD_D_RF = 2'd0, FWD_D_EX = 2'd1, FWD_D_MEM = 2'd2} fwd_d_e;
   // EX-stage operand source
   typedef enum logic [1:0] {FWD_E_LATCH = 2'd0, FWD_E_MEM = 2'd1, FWD_E_WB = 2'd2} fwd_e_e;
   // MEM store-data source
   typedef enum logic {FWD_M_LATCH = 1'b0, FWD_M_WB = 1'b1} fwd_m_e;

   // A register match that $0 can never satisfy
   function automatic logic reg_hit(reg_t r, reg_t a3);
      return (r != 5'd0) && (r == a3);
   endfunction

   // Tnew counts down one per stage and parks at 0
   function automatic tnew_t tnew_dec(tnew_t t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

endpackage

// File: rtl/decode.sv
// Instruction classifier: source/destination registers plus Tuse/Tnew.
module decode
   import mips_pkg::*;
(
   input  logic [31:0] instr_i,
   output reg_t        a1_o,
   output reg_t        a2_o,
   output reg_t        a3_o,
   output tuse_t       tuse_rs_o,
   output tuse_t       tuse_rt_o,
   output tnew_t       tnew_o
);

   logic [5:0] op;
   logic [5:0] funct;
   reg_t       rd;
   logic       unused_shamt;

   assign op    = instr_i[31:26];
   assign funct = instr_i[5:0];
   assign rd    = instr_i[15:11];
   assign a1_o  = instr_i[25:21];
   assign a2_o  = instr_i[20:16];
   assign unused_shamt = ^instr_i[10:6];

   // Per-opcode destination and operand timing; unknown opcodes write nothing
   always_comb begin
      a3_o      = 5'd0;
      tuse_rs_o = TUSE_NONE;
      tuse_rt_o = TUSE_NONE;
      tnew_o    = 2'd0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               F_ADDU, F_SUBU, F_SLT: begin
                  a3_o      = rd;
                  tuse_rs_o = 2'd1;
                  tuse_rt_o = 2'd1;
                  tnew_o    = 2'd1;
               end
               F_JR:    tuse_rs_o = 2'd0;
               default: ;
            endcase
         end
         OP_ORI, OP_ADDI, OP_ADDIU: begin
            a3_o      = a2_o;
            tuse_rs_o = 2'd1;
            tnew_o    = 2'd1;
         end
         OP_LUI: begin
            a3_o   = a2_o;
            tnew_o = 2'd1;
         end
         OP_LW: begin
            a3_o      = a2_o;
            tuse_rs_o = 2'd1;
            tnew_o    = 2'd2;
         end
         OP_SW: begin
            tuse_rs_o = 2'd1;
            tuse_rt_o = 2'd2;
         end
         OP_BEQ: begin
            tuse_rs_o = 2'd0;
            tuse_rt_o = 2'd0;
         end
         OP_JAL: begin
            a3_o   = 5'd31;
            tnew_o = 2'd0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall and forwarding control for a classic 5-stage MIPS pipeline using
// Tuse/Tnew scheduling. Shadow registers mirror the EX/MEM/WB occupants.
module hazard_ctrl
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr_id,
   output logic        stall,
   output logic [1:0]  fwd_rs_d,
   output logic [1:0]  fwd_rt_d,
   output logic [1:0]  fwd_rs_e,
   output logic [1:0]  fwd_rt_e,
   output logic        fwd_rt_m
);

   reg_t  id_rs, id_rt, id_a3;
   tuse_t tuse_rs, tuse_rt;
   tnew_t id_tnew;

   reg_t  rs_e_q, rt_e_q, a3_e_q, rt_m_q, a3_m_q, a3_w_q;
   tnew_t tnew_e_q, tnew_m_q;
   reg_t  rs_e_d, rt_e_d, a3_e_d, rt_m_d, a3_m_d, a3_w_d;
   tnew_t tnew_e_d, tnew_m_d;

   logic  stall_rs, stall_rt;

   decode u_decode (
      .instr_i   (instr_id),
      .a1_o      (id_rs),
      .a2_o      (id_rt),
      .a3_o      (id_a3),
      .tuse_rs_o (tuse_rs),
      .tuse_rt_o (tuse_rt),
      .tnew_o    (id_tnew)
   );

   // Stall when a producer in EX or MEM cannot deliver before the consumer needs it
   always_comb begin
      stall_rs = (reg_hit(id_rs, a3_e_q) && (tuse_rs < tnew_e_q)) ||
                 (reg_hit(id_rs, a3_m_q) && (tuse_rs < tnew_m_q));
      stall_rt = (reg_hit(id_rt, a3_e_q) && (tuse_rt < tnew_e_q)) ||
                 (reg_hit(id_rt, a3_m_q) && (tuse_rt < tnew_m_q));
      stall    = stall_rs || stall_rt;
   end

   // Forward selects: ID prefers EX over MEM (WB handled by regfile bypass),
   // EX prefers MEM over WB, MEM store data only from WB
   always_comb begin
      fwd_rs_d = FWD_D_RF;
      fwd_rt_d = FWD_D_RF;
      fwd_rs_e = FWD_E_LATCH;
      fwd_rt_e = FWD_E_LATCH;
      fwd_rt_m = FWD_M_LATCH;
      if (reg_hit(id_rs, a3_e_q) && tnew_e_q == 2'd0)      fwd_rs_d = FWD_D_EX;
      else if (reg_hit(id_rs, a3_m_q) && tnew_m_q == 2'd0) fwd_rs_d = FWD_D_MEM;
      if (reg_hit(id_rt, a3_e_q) && tnew_e_q == 2'd0)      fwd_rt_d = FWD_D_EX;
      else if (reg_hit(id_rt, a3_m_q) && tnew_m_q == 2'd0) fwd_rt_d = FWD_D_MEM;
      if (reg_hit(rs_e_q, a3_m_q) && tnew_m_q == 2'd0)     fwd_rs_e = FWD_E_MEM;
      else if (reg_hit(rs_e_q, a3_w_q))                    fwd_rs_e = FWD_E_WB;
      if (reg_hit(rt_e_q, a3_m_q) && tnew_m_q == 2'd0)     fwd_rt_e = FWD_E_MEM;
      else if (reg_hit(rt_e_q, a3_w_q))                    fwd_rt_e = FWD_E_WB;
      if (reg_hit(rt_m_q, a3_w_q))                         fwd_rt_m = FWD_M_WB;
   end

   // Advance the shadow pipe; a stall drops a bubble into EX
   always_comb begin
      rs_e_d   = stall ? 5'd0 : id_rs;
      rt_e_d   = stall ? 5'd0 : id_rt;
      a3_e_d   = stall ? 5'd0 : id_a3;
      tnew_e_d = stall ? 2'd0 : id_tnew;
      rt_m_d   = rt_e_q;
      a3_m_d   = a3_e_q;
      tnew_m_d = tnew_dec(tnew_e_q);
      a3_w_d   = a3_m_q;
   end

   // Shadow registers, cleared immediately by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs_e_q   <= 5'd0;
         rt_e_q   <= 5'd0;
         a3_e_q   <= 5'd0;
         tnew_e_q <= 2'd0;
         rt_m_q   <= 5'd0;
         a3_m_q   <= 5'd0;
         tnew_m_q <= 2'd0;
         a3_w_q   <= 5'd0;
      end else begin
         rs_e_q   <= rs_e_d;
         rt_e_q   <= rt_e_d;
         a3_e_q   <= a3_e_d;
         tnew_e_q <= tnew_e_d;
         rt_m_q   <= rt_m_d;
         a3_m_q   <= a3_m_d;
         tnew_m_q <= tnew_m_d;
         a3_w_q   <= a3_w_d;
      end
   end

endmodule
